keypoint_collector: RTL and testbench
=====================================

Name: keypoint_collector

Overview:
- Sink end of the FAST_Detector output stream. Consumes the per-pixel keypoint stream (flag, X, Y, score, orientation) bracketed by frame start and end pulses.
- Filters keypoints by score and stores up to DEPTH of them per frame in a register buffer.
- After the frame ends, drains the stored list through a valid/ready port to the downstream descriptor/matching stage.

Parameters:
- DEPTH, 256, keypoint buffer entries (power of two)
- AW, 8, log2(DEPTH); buffer address width
- THRESH, 8'd20, minimum score accepted (inclusive)

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  frame-start pulse from detector (o_start)
- i_end  input  1  frame-end pulse from detector (o_end)
- i_flag  input  1  keypoint valid this cycle
- i_coord_X  input  10  keypoint column
- i_coord_Y  input  10  keypoint row
- i_orientation  input  10  keypoint orientation
- i_score  input  8  keypoint score
- o_valid  output  1  drain entry valid
- i_ready  input  1  downstream accepts entry
- o_kp_X  output  10  drained column
- o_kp_Y  output  10  drained row
- o_kp_orient  output  10  drained orientation
- o_kp_score  output  8  drained score
- o_last  output  1  current drained entry is the final one
- o_kp_count  output  AW+1  keypoints stored this frame (0..DEPTH)
- o_overflow  output  1  sticky per frame: a qualifying keypoint was dropped because the buffer was full
- o_frame_done  output  1  one-cycle pulse when drain completes
- o_busy  output  1  state != IDLE

Behaviour:
- Interface: one clock i_clk; reset i_rst_n is asynchronous, active-low. All state is reset asynchronously.
- Reset values: state IDLE; write/read pointers 0; o_kp_count 0; o_overflow 0; o_valid 0; o_last 0; o_frame_done 0; o_busy 0. The buffer array is not reset.
- States: IDLE, COLLECT, DRAIN.
- IDLE:
  - i_start -> clear count, pointers and o_overflow; go to COLLECT next cycle.
  - All other inputs are ignored.
- COLLECT, each cycle:
  - i_flag && i_score >= THRESH && count < DEPTH -> write {X, Y, orient, score} at wr_ptr; wr_ptr++ and count++ (visible next cycle).
  - Qualifying keypoint while count == DEPTH -> drop it and set o_overflow (stays set until the next accepted i_start).
  - i_flag with score < THRESH -> ignored silently.
- COLLECT, i_end:
  - A keypoint presented in the same cycle as i_end is processed first.
  - Then go to DRAIN next cycle.
  - i_start inside COLLECT -> ignored (no restart).
- DRAIN:
  - o_valid = (rd_ptr < count). Output fields are driven combinationally from buffer[rd_ptr].
  - o_last = o_valid && (rd_ptr == count-1).
  - Handshake: on o_valid && i_ready, rd_ptr++ next cycle. Data is held stable while o_valid && !i_ready. o_valid never drops without a handshake.
  - When the last entry hands off, or on the first DRAIN cycle if count == 0: pulse o_frame_done for one cycle and go to IDLE.
  - i_start during DRAIN -> ignored; that frame is lost (the upstream must gap frames).
- Latency:
  - First o_valid is asserted 1 cycle after the cycle i_end is sampled.
  - Sustained drain throughput is 1 entry/cycle with i_ready held high.
- o_kp_count and o_overflow remain readable in IDLE until the next i_start.
- Widths: count is AW+1 bits so DEPTH is representable. Pointers are AW bits and never wrap within a frame, since the count guard blocks writes at DEPTH.
- Reset mid-operation: returns to IDLE immediately. A partially drained frame is discarded and o_valid drops asynchronously.

Decomposition:
- Shared package vo_pkg:
  - Coordinate width (10), score width (8) and orientation width (10) constants.
  - Packed keypoint typedef kp_t {X, Y, orient, score} (38 bits), reused by the descriptor stage.
  - State enum for collector states.
- One sub-module: kp_buffer — a DEPTH x 38 register array with a synchronous write port and an asynchronous read port.
- FSM, pointers and filter logic stay in keypoint_collector.

Test Plan:
- Basic frame: i_start; 3 flags with scores 30, 10, 50 at (5,7), (6,7), (100,200); i_end; i_ready=1 -> 2 entries drained, (5,7,30) then (100,200,50); o_last on the 2nd; o_kp_count=2; o_frame_done one cycle after the 2nd handshake.
- Threshold edge: scores 19, 20, 21 -> scores 20 and 21 stored; o_kp_count=2.
- Overflow: 260 qualifying keypoints -> o_kp_count=256; o_overflow=1; drained entries are the first 256 in arrival order; the next frame's i_start clears o_overflow.
- Backpressure: i_ready toggles 1,0,0,1 during drain -> o_kp_* stable through stalled cycles; no entry duplicated or skipped.
- Empty and simultaneous events:
  - Frame with 0 flags -> o_valid never asserts; o_frame_done pulses on the first DRAIN cycle.
  - Flag coincident with i_end -> that keypoint is stored.
- Protocol misuse and reset:
  - i_start during COLLECT or DRAIN -> ignored; contents unaffected.
  - i_rst_n low mid-drain -> o_valid=0 and state IDLE immediately; next i_start starts a clean frame.

Source files
------------

// File: rtl/vo_pkg.sv
// Shared keypoint types for the FAST detector back end: field widths,
// packed keypoint record and collector state encoding.
package vo_pkg;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned SCORE_W  = 8;
    localparam int unsigned ORIENT_W = 10;
    localparam int unsigned KP_W     = 2 * COORD_W + ORIENT_W + SCORE_W;

    typedef struct packed {
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
        logic [ORIENT_W-1:0] orient;
        logic [SCORE_W-1:0]  score;
    } kp_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } kpc_state_t;

endpackage

// File: rtl/kp_buffer.sv
// Keypoint storage: DEPTH x kp_t register array, synchronous write,
// asynchronous read. Contents are intentionally not reset.
module kp_buffer
    import vo_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  kp_t           wdata,
    input  logic [AW-1:0] raddr,
    output kp_t           rdata
);

    kp_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/keypoint_collector.sv
// Collects score-filtered keypoints for one frame, then drains them in
// arrival order over a valid/ready port once the frame has ended.
module keypoint_collector
    import vo_pkg::*;
#(
    parameter int unsigned        DEPTH  = 256,
    parameter int unsigned        AW     = 8,
    parameter logic [SCORE_W-1:0] THRESH = 8'd20
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_end,
    input  logic                i_flag,
    input  logic [COORD_W-1:0]  i_coord_X,
    input  logic [COORD_W-1:0]  i_coord_Y,
    input  logic [ORIENT_W-1:0] i_orientation,
    input  logic [SCORE_W-1:0]  i_score,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [COORD_W-1:0]  o_kp_X,
    output logic [COORD_W-1:0]  o_kp_Y,
    output logic [ORIENT_W-1:0] o_kp_orient,
    output logic [SCORE_W-1:0]  o_kp_score,
    output logic                o_last,
    output logic [AW:0]         o_kp_count,
    output logic                o_overflow,
    output logic                o_frame_done,
    output logic                o_busy
);

    kpc_state_t    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          frame_done_q, frame_done_d;

    logic          wr_en;
    kp_t           wr_kp;
    kp_t           rd_kp;
    logic          kp_qualifies;
    logic          buf_full;
    logic          drain_valid;
    logic          drain_last;
    logic          handshake;

    assign wr_kp        = {i_coord_X, i_coord_Y, i_orientation, i_score};
    assign kp_qualifies = i_flag && (i_score >= THRESH);
    assign buf_full     = (count_q == (AW+1)'(DEPTH));

    // Drain-side status is derived from registers so reset drops o_valid at once
    assign drain_valid = (state_q == ST_DRAIN) && ({1'b0, rd_ptr_q} < count_q);
    assign drain_last  = drain_valid && ({1'b0, rd_ptr_q} == (count_q - (AW+1)'(1)));
    assign handshake   = drain_valid && i_ready;

    kp_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_kp_buffer (
        .clk   (i_clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wr_kp),
        .raddr (rd_ptr_q),
        .rdata (rd_kp)
    );

    // Next-state, pointer and filter logic
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;
        wr_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d    = ST_COLLECT;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end

            ST_COLLECT: begin
                if (kp_qualifies) begin
                    if (buf_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        count_d  = count_q + (AW+1)'(1);
                    end
                end
                if (i_end) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (count_q == '0) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if (handshake) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    if (drain_last) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_valid      = drain_valid;
    assign o_last       = drain_last;
    assign o_kp_X       = rd_kp.x;
    assign o_kp_Y       = rd_kp.y;
    assign o_kp_orient  = rd_kp.orient;
    assign o_kp_score   = rd_kp.score;
    assign o_kp_count   = count_q;
    assign o_overflow   = overflow_q;
    assign o_frame_done = frame_done_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_keypoint_collector.sv
// Scoreboard bench for keypoint_collector: stimulus pushes expected drained
// entries, a negedge monitor compares whatever the DUT presents.
module tb_keypoint_collector;
    import vo_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start, i_end, i_flag, i_ready;
    logic [9:0]    i_coord_X, i_coord_Y, i_orientation;
    logic [7:0]    i_score;
    logic          o_valid, o_last, o_overflow, o_frame_done, o_busy;
    logic [9:0]    o_kp_X, o_kp_Y, o_kp_orient;
    logic [7:0]    o_kp_score;
    logic [8:0]    o_kp_count;

    int  vectors = 0;
    int  errors  = 0;
    int  cyc     = 0;
    int  hs_count = 0;
    int  last_hs_cyc = 0;
    int  exp_count = 0;
    kp_t exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keypoint_collector dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (i_start),
        .i_end         (i_end),
        .i_flag        (i_flag),
        .i_coord_X     (i_coord_X),
        .i_coord_Y     (i_coord_Y),
        .i_orientation (i_orientation),
        .i_score       (i_score),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_kp_X        (o_kp_X),
        .o_kp_Y        (o_kp_Y),
        .o_kp_orient   (o_kp_orient),
        .o_kp_score    (o_kp_score),
        .o_last        (o_last),
        .o_kp_count    (o_kp_count),
        .o_overflow    (o_overflow),
        .o_frame_done  (o_frame_done),
        .o_busy        (o_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented entry must match the queue head; pop on handshake
    always @(negedge clk) begin
        kp_t head;
        if (rst_n && o_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 64'(o_valid), 64'd0);
            end else begin
                head = exp_q[0];
                check(i_ready ? "drain_entry" : "stall_hold",
                      64'({o_kp_X, o_kp_Y, o_kp_orient, o_kp_score, o_last}),
                      64'({head, exp_q.size() == 1}));
                if (i_ready) begin
                    head = exp_q.pop_front();
                    hs_count++;
                    last_hs_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        exp_count = 0;
        hs_count  = 0;
    endtask

    // One keypoint for one cycle; with_end also raises i_end in that cycle
    task automatic send_kp(input int x, input int y, input int orient, input int score, input bit with_end);
        kp_t k;
        i_flag        = 1'b1;
        i_coord_X     = 10'(x);
        i_coord_Y     = 10'(y);
        i_orientation = 10'(orient);
        i_score       = 8'(score);
        i_end         = with_end;
        k = {10'(x), 10'(y), 10'(orient), 8'(score)};
        if (score >= 20 && exp_count < 256) begin
            exp_q.push_back(k);
            exp_count++;
        end
        tick();
        i_flag = 1'b0;
        i_end  = 1'b0;
    endtask

    task automatic end_frame();
        i_end = 1'b1;
        tick();
        i_end = 1'b0;
    endtask

    // Drain with a repeating 4-cycle ready pattern until o_frame_done (bounded)
    task automatic drain(input logic [3:0] pat, input int start_at, input int exp_cycles);
        int  cycles = 0;
        bit  done = 1'b0;
        int  done_cyc = 0;
        while (!done && cycles < 700) begin
            i_ready = pat[cycles % 4];
            i_start = (cycles == start_at);
            @(negedge clk);
            if (cycles == 0) begin
                check("first_valid_latency", 64'(o_valid), 64'(exp_count > 0));
                check("count_in_drain", 64'(o_kp_count), 64'(exp_count));
            end
            cycles++;
            if (o_frame_done) begin
                done = 1'b1;
                done_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        i_ready = 1'b0;
        i_start = 1'b0;
        check("frame_done_seen", 64'(done), 64'd1);
        check("frame_done_cycles", 64'(cycles), 64'(exp_cycles));
        check("handshakes", 64'(hs_count), 64'(exp_count));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        if (exp_count > 0) begin
            check("done_after_last_hs", 64'(done_cyc - last_hs_cyc), 64'd1);
        end
        @(negedge clk);
        check("frame_done_pulse", 64'(o_frame_done), 64'd0);
        check("busy_after_done", 64'(o_busy), 64'd0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        i_start = 1'b0; i_end = 1'b0; i_flag = 1'b0; i_ready = 1'b0;
        i_coord_X = '0; i_coord_Y = '0; i_orientation = '0; i_score = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_count", 64'(o_kp_count), 64'd0);
        check("rst_overflow", 64'(o_overflow), 64'd0);
        check("rst_frame_done", 64'(o_frame_done), 64'd0);
        check("rst_last", 64'(o_last), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic frame: score 10 filtered out
        start_frame();
        check("busy_collect", 64'(o_busy), 64'd1);
        send_kp(5, 7, 11, 30, 1'b0);
        send_kp(6, 7, 12, 10, 1'b0);
        send_kp(100, 200, 13, 50, 1'b0);
        end_frame();
        drain(4'b1111, -1, 3);
        check("basic_count_idle", 64'(o_kp_count), 64'd2);

        // Threshold edge
        start_frame();
        send_kp(1, 1, 1, 19, 1'b0);
        send_kp(2, 1, 2, 20, 1'b0);
        send_kp(3, 1, 3, 21, 1'b0);
        end_frame();
        drain(4'b1111, -1, 3);
        check("thresh_count", 64'(o_kp_count), 64'd2);
        check("thresh_overflow", 64'(o_overflow), 64'd0);

        // Overflow: 260 qualifying keypoints, first 256 kept
        start_frame();
        for (int i = 0; i < 260; i++) begin
            send_kp(i, (i * 2) % 1024, 1023 - i, 20 + (i % 100), 1'b0);
        end
        end_frame();
        @(negedge clk);
        check("ovf_count", 64'(o_kp_count), 64'd256);
        check("ovf_flag", 64'(o_overflow), 64'd1);
        @(posedge clk);
        #1;
        drain(4'b1111, -1, 257);
        check("ovf_flag_idle", 64'(o_overflow), 64'd1);

        // Backpressure 1,0,0,1; next start clears overflow
        start_frame();
        check("ovf_cleared", 64'(o_overflow), 64'd0);
        send_kp(10, 20, 30, 40, 1'b0);
        send_kp(11, 21, 31, 41, 1'b0);
        send_kp(12, 22, 32, 42, 1'b0);
        send_kp(13, 23, 33, 43, 1'b0);
        end_frame();
        drain(4'b1001, -1, 9);

        // Empty frame
        start_frame();
        end_frame();
        drain(4'b1111, -1, 2);
        check("empty_count", 64'(o_kp_count), 64'd0);

        // Keypoint coincident with i_end
        start_frame();
        send_kp(300, 400, 500, 60, 1'b0);
        send_kp(301, 401, 501, 61, 1'b1);
        drain(4'b1111, -1, 3);
        check("coincident_count", 64'(o_kp_count), 64'd2);

        // i_start inside COLLECT and DRAIN ignored
        start_frame();
        send_kp(7, 8, 9, 200, 1'b0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        send_kp(17, 18, 19, 201, 1'b0);
        send_kp(27, 28, 29, 202, 1'b1);
        drain(4'b1100, 1, 8);
        check("misuse_count", 64'(o_kp_count), 64'd3);

        // Reset mid-drain
        start_frame();
        send_kp(1, 2, 3, 40, 1'b0);
        send_kp(4, 5, 6, 41, 1'b0);
        send_kp(7, 8, 9, 42, 1'b1);
        i_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 64'(o_valid), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(o_valid), 64'd0);
        check("async_rst_busy", 64'(o_busy), 64'd0);
        check("async_rst_count", 64'(o_kp_count), 64'd0);
        exp_q.delete();
        exp_count = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        start_frame();
        send_kp(11, 22, 33, 99, 1'b1);
        drain(4'b1111, -1, 2);
        check("post_rst_count", 64'(o_kp_count), 64'd1);
        check("post_rst_overflow", 64'(o_overflow), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
